// File: rtl/xdma_finish_sender.sv
// Finish-token sender: buffers finish tokens and turns each one into a single-beat remote write.
// Each write waits for its acknowledge. The write is retried on an error response or a timeout, and the token is dropped once the retries are used up.
module xdma_finish_sender #(
   parameter int unsigned IdWidth       = 8,
   parameter int unsigned AddrWidth     = 48,
   parameter int unsigned DataWidth     = 512,
   parameter int unsigned LenWidth      = 32,
   parameter int unsigned FifoDepth     = 2,
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned MaxRetries    = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [IdWidth-1:0]   finish_dma_id_i,
   input  logic [AddrWidth-1:0] finish_from_i,
   input  logic [AddrWidth-1:0] finish_dst_addr_i,
   input  logic                 finish_valid_i,
   output logic                 finish_ready_o,
   output logic [AddrWidth-1:0] req_addr_o,
   output logic [LenWidth-1:0]  req_len_o,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 data_valid_o,
   input  logic                 data_ready_i,
   input  logic                 ack_valid_i,
   input  logic                 ack_err_i,
   output logic                 ack_ready_o,
   input  logic                 error_clear_i,
   output logic                 busy_o,
   output logic                 error_o,
   output logic [7:0]           drop_count_o
);

   localparam int unsigned PtrWidth   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned CntWidth   = $clog2(FifoDepth + 1);
   localparam int unsigned TimerWidth = $clog2(TimeoutCycles);
   localparam int unsigned RetryWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

   localparam logic [PtrWidth-1:0]   PtrLast   = PtrWidth'(FifoDepth - 1);
   localparam logic [CntWidth-1:0]   CountFull = CntWidth'(FifoDepth);
   localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);
   localparam logic [RetryWidth-1:0] RetryMax  = RetryWidth'(MaxRetries);

   typedef enum logic [2:0] {IDLE, REQ, DATA, WAIT_ACK, DROP} state_e;

   state_e                state, state_next;
   logic [IdWidth-1:0]    id_mem   [FifoDepth];
   logic [AddrWidth-1:0]  from_mem [FifoDepth];
   logic [AddrWidth-1:0]  dst_mem  [FifoDepth];
   logic [PtrWidth-1:0]   wr_ptr, rd_ptr;
   logic [CntWidth-1:0]   count;
   logic [TimerWidth-1:0] timer;
   logic [RetryWidth-1:0] retry_cnt;
   logic                  ready_en;
   logic                  fifo_full, fifo_empty, push, pop, retry, drop;

   assign fifo_full      = (count == CountFull);
   assign fifo_empty     = (count == '0);
   // ready_en holds finish_ready_o low while reset is asserted.
   assign finish_ready_o = ready_en & ~fifo_full;
   assign push           = finish_valid_i & finish_ready_o;
   assign busy_o         = ~fifo_empty | (state != IDLE);
   assign req_addr_o     = dst_mem[rd_ptr];
   assign req_len_o      = LenWidth'(1);

   always_comb begin
      data_o                        = '0;
      data_o[IdWidth-1:0]           = id_mem[rd_ptr];
      data_o[IdWidth +: AddrWidth]  = from_mem[rd_ptr];
   end

   // NOTE: the token buffer is reset on purpose (it is tiny), so the head-driven outputs read 0 in reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(FifoDepth); i++) begin
            id_mem[i]   <= '0;
            from_mem[i] <= '0;
            dst_mem[i]  <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (push) begin
            id_mem[wr_ptr]   <= finish_dma_id_i;
            from_mem[wr_ptr] <= finish_from_i;
            dst_mem[wr_ptr]  <= finish_dst_addr_i;
            wr_ptr           <= (wr_ptr == PtrLast) ? '0 : wr_ptr + PtrWidth'(1);
         end
         if (pop) rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + PtrWidth'(1);
         case ({push, pop})
            2'b10:   count <= count + CntWidth'(1);
            2'b01:   count <= count - CntWidth'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next   = state;
      req_valid_o  = 1'b0;
      data_valid_o = 1'b0;
      ack_ready_o  = 1'b0;
      pop          = 1'b0;
      retry        = 1'b0;
      drop         = 1'b0;
      unique case (state)
         IDLE: if (!fifo_empty) state_next = REQ;
         REQ: begin
            req_valid_o = 1'b1;
            if (req_ready_i) state_next = DATA;
         end
         DATA: begin
            data_valid_o = 1'b1;
            if (data_ready_i) state_next = WAIT_ACK;
         end
         WAIT_ACK: begin
            ack_ready_o = 1'b1;
            // A response that lands on the timeout cycle wins; its err bit decides.
            if (ack_valid_i && !ack_err_i) begin
               pop        = 1'b1;
               state_next = IDLE;
            end else if (ack_valid_i || timer == TimerLast) begin
               if (retry_cnt < RetryMax) begin
                  retry      = 1'b1;
                  state_next = REQ;
               end else begin
                  state_next = DROP;
               end
            end
         end
         DROP: begin
            pop        = 1'b1;
            drop       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer        <= '0;
         retry_cnt    <= '0;
         error_o      <= 1'b0;
         drop_count_o <= '0;
      end else begin
         if (state == DATA && data_ready_i) timer <= '0;
         else if (state == WAIT_ACK)        timer <= timer + TimerWidth'(1);
         if (pop)        retry_cnt <= '0;
         else if (retry) retry_cnt <= retry_cnt + RetryWidth'(1);
         if (drop)               error_o <= 1'b1;
         else if (error_clear_i) error_o <= 1'b0;
         if (drop && drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
      end
   end

endmodule

// File: tb/tb_xdma_finish_sender.sv
// Self-checking bench for xdma_finish_sender: a table of per-cycle vectors for the basic flow.
// Hand-written sequences cover back-pressure, retries, timeouts, drops and mid-flight reset.
module tb_xdma_finish_sender;

   typedef struct {
      logic [7:0]  id;
      logic [47:0] from;
      logic [47:0] dst;
   } tok_t;

   typedef struct {
      int delay;  // WAIT_ACK cycles before responding; -1 never responds
      bit err;
   } plan_t;

   typedef struct {
      logic fv, rr, dr, av, ae;
      logic e_req, e_data, e_ack, e_busy, e_rdy;
   } vec_t;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic [7:0]   finish_dma_id_i = '0;
   logic [47:0]  finish_from_i = '0;
   logic [47:0]  finish_dst_addr_i = '0;
   logic         finish_valid_i = 1'b0;
   logic         finish_ready_o;
   logic [47:0]  req_addr_o;
   logic [31:0]  req_len_o;
   logic         req_valid_o;
   logic         req_ready_i = 1'b0;
   logic [511:0] data_o;
   logic         data_valid_o;
   logic         data_ready_i = 1'b0;
   logic         ack_valid_i = 1'b0;
   logic         ack_err_i = 1'b0;
   logic         ack_ready_o;
   logic         error_clear_i = 1'b0;
   logic         busy_o;
   logic         error_o;
   logic [7:0]   drop_count_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   tok_t        push_q[$];
   plan_t       ack_plan[$];
   logic [47:0] req_addr_q[$];
   int          req_cyc_q[$];
   logic [511:0] data_q[$];
   int          data_cyc_q[$];

   xdma_finish_sender #(.TimeoutCycles(16), .MaxRetries(3), .FifoDepth(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .finish_dma_id_i(finish_dma_id_i), .finish_from_i(finish_from_i),
      .finish_dst_addr_i(finish_dst_addr_i), .finish_valid_i(finish_valid_i),
      .finish_ready_o(finish_ready_o),
      .req_addr_o(req_addr_o), .req_len_o(req_len_o), .req_valid_o(req_valid_o),
      .req_ready_i(req_ready_i),
      .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
      .ack_valid_i(ack_valid_i), .ack_err_i(ack_err_i), .ack_ready_o(ack_ready_o),
      .error_clear_i(error_clear_i), .busy_o(busy_o), .error_o(error_o),
      .drop_count_o(drop_count_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [511:0] pack(input tok_t t);
      logic [511:0] p;
      p        = '0;
      p[7:0]   = t.id;
      p[55:8]  = t.from;
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic drive_tok(input tok_t t);
      finish_valid_i    = 1'b1;
      finish_dma_id_i   = t.id;
      finish_from_i     = t.from;
      finish_dst_addr_i = t.dst;
   endtask

   // Pushes push_q, answers acks from ack_plan and logs handshakes until idle or budget runs out.
   task automatic run(input string tag, input int max_cycles, input int exp_req, input int clear_on_attempt);
      plan_t cur;
      int    wait_cnt = 0;
      int    n_data = 0;
      int    clr_cycle = -1;
      bit    done = 0;
      bit    push_fire;
      cur.delay = 0;
      cur.err   = 1'b0;
      req_addr_q.delete();
      req_cyc_q.delete();
      data_q.delete();
      data_cyc_q.delete();
      for (int k = 0; k < max_cycles; k++) begin
         if (push_q.size() > 0) drive_tok(push_q[0]);
         else finish_valid_i = 1'b0;
         error_clear_i = (cyc == clr_cycle);
         ack_valid_i   = 1'b0;
         ack_err_i     = 1'b0;
         if (ack_ready_o) begin
            if (cur.delay == wait_cnt) begin
               ack_valid_i = 1'b1;
               ack_err_i   = cur.err;
            end
            wait_cnt++;
         end
         #1;
         push_fire = finish_valid_i && finish_ready_o;
         if (req_valid_o && req_ready_i) begin
            req_addr_q.push_back(req_addr_o);
            req_cyc_q.push_back(cyc);
         end
         if (data_valid_o && data_ready_i) begin
            data_q.push_back(data_o);
            data_cyc_q.push_back(cyc);
            n_data++;
            if (ack_plan.size() > 0) cur = ack_plan.pop_front();
            else begin
               cur.delay = 0;
               cur.err   = 1'b0;
            end
            wait_cnt = 0;
            if (n_data == clear_on_attempt) clr_cycle = cyc + 2;
         end
         step();
         if (push_fire) void'(push_q.pop_front());
         if (push_q.size() == 0 && !busy_o && req_addr_q.size() >= exp_req) begin
            done = 1;
            break;
         end
      end
      finish_valid_i = 1'b0;
      ack_valid_i    = 1'b0;
      ack_err_i      = 1'b0;
      error_clear_i  = 1'b0;
      check({tag, "_done"}, 64'(done), 64'd1);
   endtask

   vec_t vecs[8];
   tok_t t1, ta, tb, tc, t3, t4a, t4b, t5a, t5b, r1, r2, r3;

   initial begin
      t1  = '{8'h05, 48'h0000_1000_0000, 48'h0000_2000_0FF8};
      ta  = '{8'h11, 48'h0000_0000_A000, 48'h0000_0000_0A08};
      tb  = '{8'h22, 48'h0000_0000_B000, 48'h0000_0000_0B08};
      tc  = '{8'h33, 48'h0000_0000_C000, 48'h0000_0000_0C08};
      t3  = '{8'h44, 48'hFFFF_FFFF_F000, 48'h0000_0000_4448};
      t4a = '{8'h55, 48'h0000_5555_0000, 48'h0000_0000_5508};
      t4b = '{8'h66, 48'h0000_6666_0000, 48'h0000_0000_6608};
      t5a = '{8'h77, 48'h0000_7777_0000, 48'h0000_0000_7708};
      t5b = '{8'h88, 48'h0000_8888_0000, 48'h0000_0000_8808};
      r1  = '{8'h91, 48'h0000_9100_0000, 48'h0000_0000_9108};
      r2  = '{8'h92, 48'h0000_9200_0000, 48'h0000_0000_9208};
      r3  = '{8'hFF, 48'h0000_9300_0000, 48'h0000_0000_9308};

      //            fv    rr    dr    av    ae    req   data  ack   busy  rdy
      vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset state
      #12;
      check("rst_req_valid", 64'(req_valid_o), 64'd0);
      check("rst_data_valid", 64'(data_valid_o), 64'd0);
      check("rst_ack_ready", 64'(ack_ready_o), 64'd0);
      check("rst_finish_ready", 64'(finish_ready_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_error", 64'(error_o), 64'd0);
      check("rst_drop_count", 64'(drop_count_o), 64'd0);
      @(posedge clk_i);
      #3 rst_ni = 1'b1;
      step();
      step();

      // Test 1: single token, table-driven per-cycle vectors
      drive_tok(t1);
      for (int i = 0; i < 8; i++) begin
         finish_valid_i = vecs[i].fv;
         req_ready_i    = vecs[i].rr;
         data_ready_i   = vecs[i].dr;
         ack_valid_i    = vecs[i].av;
         ack_err_i      = vecs[i].ae;
         #1;
         check($sformatf("t1_v%0d_req_valid", i), 64'(req_valid_o), 64'(vecs[i].e_req));
         check($sformatf("t1_v%0d_data_valid", i), 64'(data_valid_o), 64'(vecs[i].e_data));
         check($sformatf("t1_v%0d_ack_ready", i), 64'(ack_ready_o), 64'(vecs[i].e_ack));
         check($sformatf("t1_v%0d_busy", i), 64'(busy_o), 64'(vecs[i].e_busy));
         check($sformatf("t1_v%0d_finish_ready", i), 64'(finish_ready_o), 64'(vecs[i].e_rdy));
         if (vecs[i].e_req) begin
            check("t1_req_addr", 64'(req_addr_o), 64'(t1.dst));
            check("t1_req_len", 64'(req_len_o), 64'd1);
         end
         if (vecs[i].e_data) begin
            check("t1_data_id", 64'(data_o[7:0]), 64'h05);
            check("t1_data_from", 64'(data_o[55:8]), 64'h1000_0000);
            check_wide("t1_data_full", data_o, pack(t1));
         end
         step();
      end
      ack_valid_i = 1'b0;

      // Test 2: back-pressure on the descriptor, third push stalls, then in-order drain
      req_ready_i  = 1'b0;
      data_ready_i = 1'b1;
      drive_tok(ta);
      #1 check("t2_push_a_ready", 64'(finish_ready_o), 64'd1);
      step();
      drive_tok(tb);
      #1 check("t2_push_b_ready", 64'(finish_ready_o), 64'd1);
      step();
      drive_tok(tc);
      #1 check("t2_push_c_stalled", 64'(finish_ready_o), 64'd0);
      check("t2_req_held", 64'(req_valid_o), 64'd1);
      step();
      #1 check("t2_push_c_still_stalled", 64'(finish_ready_o), 64'd0);
      check("t2_req_addr_head", 64'(req_addr_o), 64'(ta.dst));
      finish_valid_i = 1'b0;
      push_q.push_back(tc);
      req_ready_i = 1'b1;
      run("t2", 200, 3, 0);
      check("t2_req_count", 64'(req_addr_q.size()), 64'd3);
      check("t2_data_count", 64'(data_q.size()), 64'd3);
      if (req_addr_q.size() == 3 && data_q.size() == 3) begin
         check("t2_req0", 64'(req_addr_q[0]), 64'(ta.dst));
         check("t2_req1", 64'(req_addr_q[1]), 64'(tb.dst));
         check("t2_req2", 64'(req_addr_q[2]), 64'(tc.dst));
         check_wide("t2_data0", data_q[0], pack(ta));
         check_wide("t2_data1", data_q[1], pack(tb));
         check_wide("t2_data2", data_q[2], pack(tc));
      end

      // Test 3: two error acks then ok
      push_q.push_back(t3);
      ack_plan.push_back('{0, 1'b1});
      ack_plan.push_back('{0, 1'b1});
      ack_plan.push_back('{0, 1'b0});
      run("t3", 100, 3, 0);
      check("t3_req_count", 64'(req_addr_q.size()), 64'd3);
      check("t3_data_count", 64'(data_q.size()), 64'd3);
      for (int i = 0; i < req_addr_q.size(); i++)
         check($sformatf("t3_req%0d", i), 64'(req_addr_q[i]), 64'(t3.dst));
      for (int i = 0; i < data_q.size(); i++)
         check_wide($sformatf("t3_data%0d", i), data_q[i], pack(t3));
      check("t3_error", 64'(error_o), 64'd0);
      check("t3_drop_count", 64'(drop_count_o), 64'd0);

      // Test 4: no ack ever -> 4 timed-out attempts, drop, next token proceeds
      push_q.push_back(t4a);
      push_q.push_back(t4b);
      for (int i = 0; i < 4; i++) ack_plan.push_back('{-1, 1'b0});
      run("t4", 400, 5, 0);
      check("t4_req_count", 64'(req_addr_q.size()), 64'd5);
      if (req_addr_q.size() == 5 && data_cyc_q.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_req%0d", i), 64'(req_addr_q[i]), 64'(t4a.dst));
            check_wide($sformatf("t4_data%0d", i), data_q[i], pack(t4a));
         end
         for (int i = 0; i < 3; i++)
            check($sformatf("t4_retry_gap%0d", i), 64'(req_cyc_q[i+1] - data_cyc_q[i]), 64'd17);
         check("t4_drop_gap", 64'(req_cyc_q[4] - data_cyc_q[3]), 64'd19);
         check("t4_next_token", 64'(req_addr_q[4]), 64'(t4b.dst));
      end
      check("t4_error", 64'(error_o), 64'd1);
      check("t4_drop_count", 64'(drop_count_o), 64'd1);

      // Test 5a: error_clear clears next cycle; ack ok on the timeout cycle is a success
      error_clear_i = 1'b1;
      step();
      error_clear_i = 1'b0;
      #1 check("t5_error_cleared", 64'(error_o), 64'd0);
      push_q.push_back(t5a);
      ack_plan.push_back('{15, 1'b0});
      run("t5a", 100, 1, 0);
      check("t5a_req_count", 64'(req_addr_q.size()), 64'd1);
      check("t5a_error", 64'(error_o), 64'd0);
      check("t5a_drop_count", 64'(drop_count_o), 64'd1);

      // Test 5b: error_clear in the DROP cycle loses to the set
      push_q.push_back(t5b);
      for (int i = 0; i < 4; i++) ack_plan.push_back('{0, 1'b1});
      run("t5b", 100, 4, 4);
      check("t5b_req_count", 64'(req_addr_q.size()), 64'd4);
      check("t5b_error_set_wins", 64'(error_o), 64'd1);
      check("t5b_drop_count", 64'(drop_count_o), 64'd2);
      error_clear_i = 1'b1;
      step();
      error_clear_i = 1'b0;
      #1 check("t5b_error_cleared", 64'(error_o), 64'd0);

      // Test 6: reset while in DATA with two tokens buffered
      req_ready_i  = 1'b1;
      data_ready_i = 1'b0;
      drive_tok(r1);
      step();
      drive_tok(r2);
      step();
      finish_valid_i = 1'b0;
      #1 check("t6_in_req", 64'(req_valid_o), 64'd1);
      step();
      #1 check("t6_in_data", 64'(data_valid_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      check("t6_rst_req_valid", 64'(req_valid_o), 64'd0);
      check("t6_rst_data_valid", 64'(data_valid_o), 64'd0);
      check("t6_rst_ack_ready", 64'(ack_ready_o), 64'd0);
      check("t6_rst_finish_ready", 64'(finish_ready_o), 64'd0);
      check("t6_rst_busy", 64'(busy_o), 64'd0);
      check("t6_rst_drop_count", 64'(drop_count_o), 64'd0);
      check("t6_rst_req_addr", 64'(req_addr_o), 64'd0);
      check_wide("t6_rst_data", data_o, 512'd0);
      step();
      step();
      rst_ni = 1'b1;
      step();
      step();
      data_ready_i = 1'b1;
      #1;
      check("t6_post_ack_ready", 64'(ack_ready_o), 64'd0);
      check("t6_post_busy", 64'(busy_o), 64'd0);
      check("t6_post_req_valid", 64'(req_valid_o), 64'd0);
      check("t6_post_finish_ready", 64'(finish_ready_o), 64'd1);
      push_q.push_back(r3);
      run("t6", 100, 1, 0);
      check("t6_req_count", 64'(req_addr_q.size()), 64'd1);
      if (req_addr_q.size() == 1) check("t6_only_new_token", 64'(req_addr_q[0]), 64'(r3.dst));
      if (data_q.size() == 1) check_wide("t6_new_data", data_q[0], pack(r3));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
